// File: rtl/fir_seq_filter_if.sv
// Sample, coefficient and status signals of the symmetric FIR filter.
// The filter uses the slave modport; the upstream driver uses master.
interface fir_seq_filter_if #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned COEF_W = 12,
  parameter int unsigned TAPS   = 31
);
  localparam int unsigned AW = $clog2((TAPS + 1) / 2);

  logic              in_valid;
  logic [DATA_W-1:0] in_sample;
  logic              in_ready;
  logic              coef_we;
  logic [AW-1:0]     coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_sample;
  logic              busy;
  logic              overrun;
  logic              clr_overrun;

  modport slave (
    input  in_valid, in_sample, coef_we, coef_addr, coef_data, clr_overrun,
    output in_ready, out_valid, out_sample, busy, overrun
  );

  modport master (
    output in_valid, in_sample, coef_we, coef_addr, coef_data, clr_overrun,
    input  in_ready, out_valid, out_sample, busy, overrun
  );
endinterface

// File: rtl/fir_seq_filter.sv
// Symmetric FIR filter: one tap pair per clock through a single multiplier,
// then a floor-shifted, saturated result with a one-cycle valid pulse.
module fir_seq_filter #(
  parameter int unsigned DATA_W    = 10,
  parameter int unsigned COEF_W    = 12,
  parameter int unsigned TAPS      = 31,
  parameter int unsigned FRAC_BITS = 10
) (
  input logic clk,
  input logic reset,
  fir_seq_filter_if.slave bus
);
  localparam int unsigned H      = (TAPS + 1) / 2;
  localparam int unsigned AW     = $clog2(H);
  localparam int unsigned TW     = $clog2(TAPS);
  localparam int unsigned PW     = DATA_W + 1;
  localparam int unsigned PROD_W = PW + COEF_W;
  localparam int unsigned ACC_W  = PROD_W + AW;
  localparam logic [ACC_W-1:0] MaxOut = ACC_W'((2 ** DATA_W) - 1);

  typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] d_q [TAPS];
  logic [DATA_W-1:0] d_d [TAPS];
  logic [COEF_W-1:0] c_q [H];
  logic [COEF_W-1:0] c_d [H];
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              overrun_q, overrun_d;

  logic [TW-1:0]     lo_idx, hi_idx;
  logic [PW-1:0]     pair;
  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  shifted;

  // Mirror tap for the current pair; the centre tap is counted once.
  always_comb begin
    lo_idx = TW'(idx_q);
    hi_idx = TW'(TAPS - 1) - lo_idx;
    if (idx_q == AW'(H - 1)) begin
      pair = PW'(d_q[lo_idx]);
    end else begin
      pair = PW'(d_q[lo_idx]) + PW'(d_q[hi_idx]);
    end
    prod    = PROD_W'(c_q[idx_q]) * PROD_W'(pair);
    shifted = acc_q >> FRAC_BITS;
  end

  always_comb begin
    state_d     = state_q;
    d_d         = d_q;
    c_d         = c_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    overrun_d   = overrun_q;

    unique case (state_q)
      StIdle: begin
        if (bus.coef_we && (32'(bus.coef_addr) < 32'(H))) begin
          c_d[bus.coef_addr] = bus.coef_data;
        end
        if (bus.in_valid) begin
          d_d[0] = bus.in_sample;
          for (int k = 1; k < int'(TAPS); k++) begin
            d_d[k] = d_q[k-1];
          end
          acc_d   = '0;
          idx_d   = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        acc_d = acc_q + ACC_W'(prod);
        idx_d = idx_q + 1'b1;
        if (idx_q == AW'(H - 1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        out_d       = (shifted > MaxOut) ? DATA_W'(MaxOut) : shifted[DATA_W-1:0];
        out_valid_d = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A drop in the same cycle as a clear leaves the flag set.
    if (bus.clr_overrun) begin
      overrun_d = 1'b0;
    end
    if (bus.in_valid && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      d_q         <= '{default: '0};
      c_q         <= '{default: '0};
      acc_q       <= '0;
      idx_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      d_q         <= d_d;
      c_q         <= c_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.in_ready   = (state_q == StIdle);
  assign bus.busy       = (state_q != StIdle);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_sample = out_q;
  assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_fir_seq_filter.sv
// Directed and randomized checks of fir_seq_filter against a full-convolution
// reference model of the symmetric filter.
module tb_fir_seq_filter;
  localparam int unsigned DATA_W    = 10;
  localparam int unsigned COEF_W    = 12;
  localparam int unsigned TAPS      = 31;
  localparam int unsigned FRAC_BITS = 10;
  localparam int unsigned H         = (TAPS + 1) / 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  fir_seq_filter_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS)) bus ();

  fir_seq_filter #(
    .DATA_W   (DATA_W),
    .COEF_W   (COEF_W),
    .TAPS     (TAPS),
    .FRAC_BITS(FRAC_BITS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int tests   = 0;
  int fails   = 0;
  int edges   = 0;
  int exp_out = 0;
  int hist [TAPS];
  int mc   [H];
  int dc_coefs [H] = '{3, 4, 6, 8, 12, 17, 23, 29, 36, 43, 50, 56, 61, 65, 67, 68};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int j = 0; j < int'(TAPS); j++) hist[j] = 0;
    for (int j = 0; j < int'(H); j++) mc[j] = 0;
  endfunction

  function automatic void model_push(input int v);
    for (int j = int'(TAPS) - 1; j > 0; j--) hist[j] = hist[j-1];
    hist[0] = v;
  endfunction

  // Plain full-length convolution with mirrored coefficients.
  function automatic int model_out();
    longint acc = 0;
    longint maxv = (longint'(1) << DATA_W) - 1;
    for (int j = 0; j < int'(TAPS); j++) begin
      int k = (j < int'(H)) ? j : int'(TAPS) - 1 - j;
      acc += longint'(mc[k]) * longint'(hist[j]);
    end
    acc = acc >>> FRAC_BITS;
    return int'((acc > maxv) ? maxv : acc);
  endfunction

  task automatic step();
    @(negedge clk);
    edges++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.coef_we = 1'b0;
    bus.clr_overrun = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic write_coef(input int a, input int v);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 4'(a);
    bus.coef_data = 12'(v);
    @(negedge clk);
    bus.coef_we = 1'b0;
    mc[a] = v;
  endtask

  task automatic accept(input int v);
    bus.in_valid  = 1'b1;
    bus.in_sample = 10'(v);
    model_push(v);
    exp_out = model_out();
    @(negedge clk);
    bus.in_valid = 1'b0;
    edges = 0;
  endtask

  task automatic wait_out(input string tag);
    do step(); while (!bus.out_valid && edges < 40);
    check({tag, " latency"}, 64'(edges), 64'd17);
    check({tag, " value"}, 64'(bus.out_sample), 64'(exp_out));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    bus.in_valid    = 1'b0;
    bus.in_sample   = '0;
    bus.coef_we     = 1'b0;
    bus.coef_addr   = '0;
    bus.coef_data   = '0;
    bus.clr_overrun = 1'b0;
    model_clear();

    do_reset();
    check("rst out_sample", 64'(bus.out_sample), 64'd0);
    check("rst out_valid", 64'(bus.out_valid), 64'd0);
    check("rst in_ready", 64'(bus.in_ready), 64'd1);
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst overrun", 64'(bus.overrun), 64'd0);

    accept(500);
    check("mac busy", 64'(bus.busy), 64'd1);
    wait_out("zero_coef");

    // Impulse through the centre tap.
    do_reset();
    write_coef(15, 1024);
    for (int i = 1; i <= 31; i++) begin
      accept(i);
      wait_out("impulse");
      check("impulse delayed", 64'(bus.out_sample), 64'((i <= 15) ? 0 : i - 15));
    end

    // DC gain 1028/1024.
    for (int a = 0; a < int'(H); a++) write_coef(a, dc_coefs[a]);
    for (int i = 0; i < 31; i++) begin
      accept(1000);
      wait_out("dc");
    end
    check("dc steady", 64'(bus.out_sample), 64'd1003);
    step();
    check("single pulse", 64'(bus.out_valid), 64'd0);

    do_reset();
    write_coef(15, 4095);
    for (int i = 0; i < 16; i++) begin
      accept(1023);
      wait_out("saturate");
    end
    check("saturate max", 64'(bus.out_sample), 64'd1023);

    // Random coefficients and samples, back-to-back accepts.
    do_reset();
    for (int a = 0; a < int'(H); a++) write_coef(a, int'($urandom_range(0, 300)));
    for (int i = 0; i < 24; i++) begin
      accept(int'($urandom_range(0, 1023)));
      wait_out("random");
    end

    // Drop a sample and attempt a coefficient write while busy.
    accept(321);
    repeat (4) step();
    bus.in_valid  = 1'b1;
    bus.in_sample = 10'd777;
    bus.coef_we   = 1'b1;
    bus.coef_addr = 4'd15;
    bus.coef_data = 12'd4095;
    step();
    bus.in_valid = 1'b0;
    bus.coef_we  = 1'b0;
    check("drop overrun", 64'(bus.overrun), 64'd1);
    check("drop in_ready", 64'(bus.in_ready), 64'd0);
    wait_out("after_drop");
    accept(654);
    wait_out("after_drop2");
    bus.clr_overrun = 1'b1;
    step();
    bus.clr_overrun = 1'b0;
    check("clr overrun", 64'(bus.overrun), 64'd0);

    accept(100);
    repeat (2) step();
    bus.in_valid    = 1'b1;
    bus.clr_overrun = 1'b1;
    step();
    bus.in_valid    = 1'b0;
    bus.clr_overrun = 1'b0;
    check("set wins", 64'(bus.overrun), 64'd1);
    wait_out("set_wins");
    bus.clr_overrun = 1'b1;
    step();
    bus.clr_overrun = 1'b0;
    check("clr again", 64'(bus.overrun), 64'd0);

    // Reset 8 edges into a MAC sequence.
    accept(900);
    repeat (7) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_clear();
    check("midrst busy", 64'(bus.busy), 64'd0);
    check("midrst in_ready", 64'(bus.in_ready), 64'd1);
    check("midrst out_sample", 64'(bus.out_sample), 64'd0);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.out_valid) pulses++;
    end
    check("midrst no pulse", 64'(pulses), 64'd0);
    accept(123);
    wait_out("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
